water_arbiter: RTL and testbench

WATER_ARBITER -- requirements
Module: water_arbiter

---
 rtl/water_arbiter.sv | 156 +++++++++++++++
 tb/tb_water_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/water_arbiter.sv
// Shared-pump arbiter: fixed priority flush > spray > disinfect, with a pump-off gap after every grant.
// Latency: a request sampled while idle drives grant/pump_on on the next cycle; done pulses in the first gap cycle.
// Backpressure: none; requests arriving while busy are held as pending bits, and repeats of one type coalesce.
module water_arbiter #(
    parameter int FLUSH_CYC = 20,
    parameter int SPRAY_CYC = 10,
    parameter int DIS_CYC   = 8,
    parameter int GAP_CYC   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_flush,
    input  logic       req_spray,
    input  logic       req_dis,
    input  logic       spray_mode,
    input  logic       abort_spray,
    output logic       pump_on,
    output logic [2:0] grant,
    output logic       done_flush,
    output logic       done_spray,
    output logic       done_dis,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    // Counters are loaded with (duration - 1) and run down to zero.
    localparam logic [8:0] FLUSH_LD      = 9'(FLUSH_CYC - 1);
    localparam logic [8:0] SPRAY_LD      = 9'(SPRAY_CYC - 1);
    localparam logic [8:0] SPRAY_LONG_LD = 9'(2 * SPRAY_CYC - 1);
    localparam logic [8:0] DIS_LD        = 9'(DIS_CYC - 1);
    localparam logic [8:0] GAP_LD        = 9'(GAP_CYC - 1);

    state_t     state_q, state_d;
    logic [8:0] cnt_q, cnt_d;
    logic [2:0] pend_q, pend_d;
    logic [2:0] grant_q, grant_d;
    logic       pump_q, pump_d;
    logic [2:0] done_q, done_d;

    logic [2:0] req_vec;
    logic [2:0] elig;
    logic [2:0] win;
    logic [8:0] win_len;
    logic       start;

    // Arbitration candidates, winner selection and its run length.
    always_comb begin
        req_vec = {req_dis, req_spray, req_flush};
        elig    = pend_q | req_vec;
        if (abort_spray) begin
            elig[1] = 1'b0;
        end
        win = 3'b000;
        if (elig[0]) begin
            win = 3'b001;
        end else if (elig[1]) begin
            win = 3'b010;
        end else if (elig[2]) begin
            win = 3'b100;
        end
        win_len = DIS_LD;
        if (win[0]) begin
            win_len = FLUSH_LD;
        end else if (win[1]) begin
            win_len = spray_mode ? SPRAY_LONG_LD : SPRAY_LD;
        end
    end

    // Next-state, counter, pending and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        done_d  = 3'b000;
        start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|win) begin
                    start = 1'b1;
                end
            end
            RUN: begin
                if (grant_q[1] && abort_spray) begin
                    // User left: stop the spray now, no completion pulse.
                    state_d = GAP;
                    cnt_d   = GAP_LD;
                    grant_d = 3'b000;
                end else if (cnt_q == 9'd0) begin
                    state_d = GAP;
                    cnt_d   = GAP_LD;
                    grant_d = 3'b000;
                    done_d  = grant_q;
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            GAP: begin
                if (cnt_q == 9'd0) begin
                    if (|win) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 9'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 9'd0;
                grant_d = 3'b000;
            end
        endcase
        if (start) begin
            state_d = RUN;
            grant_d = win;
            cnt_d   = win_len;
            pend_d  = elig & ~win;
        end else begin
            pend_d  = elig;
        end
        pump_d = |grant_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 9'd0;
            pend_q  <= 3'b000;
            grant_q <= 3'b000;
            pump_q  <= 1'b0;
            done_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            pump_q  <= pump_d;
            done_q  <= done_d;
        end
    end

    assign pump_on    = pump_q;
    assign grant      = grant_q;
    assign done_flush = done_q[0];
    assign done_spray = done_q[1];
    assign done_dis   = done_q[2];
    assign busy       = (state_q != IDLE) || (|pend_q);

endmodule

// File: tb/tb_water_arbiter.sv
// Directed bench for water_arbiter with a cycle-level reference model.
// Latency: checks every cycle at the falling edge; literal checks pin key cycles.
// Backpressure: not applicable; stimulus is one-cycle pulses.
module tb_water_arbiter;

    localparam int FLUSH = 20;
    localparam int SPRAY = 10;
    localparam int DIS   = 8;
    localparam int GAP   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_flush = 1'b0;
    logic       req_spray = 1'b0;
    logic       req_dis = 1'b0;
    logic       spray_mode = 1'b0;
    logic       abort_spray = 1'b0;
    logic       pump_on;
    logic [2:0] grant;
    logic       done_flush;
    logic       done_spray;
    logic       done_dis;
    logic       busy;

    water_arbiter #(
        .FLUSH_CYC(FLUSH),
        .SPRAY_CYC(SPRAY),
        .DIS_CYC(DIS),
        .GAP_CYC(GAP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_flush(req_flush),
        .req_spray(req_spray),
        .req_dis(req_dis),
        .spray_mode(spray_mode),
        .abort_spray(abort_spray),
        .pump_on(pump_on),
        .grant(grant),
        .done_flush(done_flush),
        .done_spray(done_spray),
        .done_dis(done_dis),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;
    bit chk_en = 1'b0;

    // {pump_on, grant[2:0], done_dis, done_spray, done_flush, busy}
    logic [7:0] dut_vec;
    assign dut_vec = {pump_on, grant, done_dis, done_spray, done_flush, busy};

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: who owns the pump, how many pump cycles remain,
    // how many gap cycles remain, and which requesters are waiting.
    bit         m_run = 1'b0;
    logic [1:0] m_own = 2'd0;
    int         m_left = 0;
    int         m_gap = 0;
    bit [2:0]   m_pend = 3'b000;
    bit [2:0]   m_done = 3'b000;

    task automatic m_pick();
        for (int i = 0; i < 3; i++) begin
            if (!m_run && m_pend[i]) begin
                m_run  = 1'b1;
                m_own  = 2'(i);
                m_pend[i] = 1'b0;
                if (i == 0)      m_left = FLUSH;
                else if (i == 1) m_left = spray_mode ? 2 * SPRAY : SPRAY;
                else             m_left = DIS;
            end
        end
    endtask

    always @(posedge clk) begin
        m_done = 3'b000;
        if (reset) begin
            m_run  = 1'b0;
            m_left = 0;
            m_gap  = 0;
            m_pend = 3'b000;
        end else begin
            if (req_flush) m_pend[0] = 1'b1;
            if (req_spray) m_pend[1] = 1'b1;
            if (req_dis)   m_pend[2] = 1'b1;
            if (abort_spray) m_pend[1] = 1'b0;
            if (m_run) begin
                if (m_own == 2'd1 && abort_spray) begin
                    m_run = 1'b0;
                    m_gap = GAP;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_done[m_own] = 1'b1;
                        m_run = 1'b0;
                        m_gap = GAP;
                    end
                end
            end else if (m_gap > 0) begin
                m_gap = m_gap - 1;
                if (m_gap == 0) m_pick();
            end else begin
                m_pick();
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [7:0] e;
            e = {m_run, (m_run ? (3'b001 << m_own) : 3'b000), m_done,
                 (m_run || (m_gap > 0) || (|m_pend))};
            tests++;
            if (dut_vec !== e) begin
                fails++;
                $display("FAIL model_cmp test_cycle %0d: got %b expected %b", cyc - t0, dut_vec, e);
            end
        end
    end

    task automatic go_to(input int n);
        while (cyc - t0 < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_at(input int n, input bit f, input bit s, input bit d,
                          input bit a, input bit m);
        go_to(n);
        req_flush   = f;
        req_spray   = s;
        req_dis     = d;
        abort_spray = a;
        spray_mode  = m;
    endtask

    task automatic lit(input int n, input string nm, input logic [7:0] expv);
        go_to(n);
        @(negedge clk);
        tests++;
        if (dut_vec !== expv) begin
            fails++;
            $display("FAIL %s cycle %0d: got %b expected %b", nm, n, dut_vec, expv);
        end
    endtask

    task automatic start_test();
        req_flush = 1'b0; req_spray = 1'b0; req_dis = 1'b0;
        abort_spray = 1'b0; spray_mode = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        t0 = cyc;
        chk_en = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single flush from idle.
        start_test();
        lit(0, "reset_state", 8'b0_000_000_0);
        set_at(5, 1, 0, 0, 0, 0);
        set_at(6, 0, 0, 0, 0, 0);
        lit(6,  "flush_first", 8'b1_001_000_1);
        lit(25, "flush_last",  8'b1_001_000_1);
        lit(26, "flush_done",  8'b0_000_001_1);
        lit(27, "flush_gap",   8'b0_000_000_1);
        lit(28, "flush_idle",  8'b0_000_000_0);

        // All three together: served in priority order with gaps.
        start_test();
        set_at(5, 1, 1, 1, 0, 0);
        set_at(6, 0, 0, 0, 0, 0);
        lit(6,  "all_flush",  8'b1_001_000_1);
        lit(26, "all_dflush", 8'b0_000_001_1);
        lit(28, "all_spray",  8'b1_010_000_1);
        lit(37, "all_slast",  8'b1_010_000_1);
        lit(38, "all_dspray", 8'b0_000_010_1);
        lit(40, "all_dis",    8'b1_100_000_1);
        lit(47, "all_dlast",  8'b1_100_000_1);
        lit(48, "all_ddis",   8'b0_000_100_1);
        lit(50, "all_idle",   8'b0_000_000_0);

        // Long spray; mode toggles mid-run are ignored.
        start_test();
        set_at(5, 0, 1, 0, 0, 1);
        set_at(6, 0, 0, 0, 0, 0);
        set_at(15, 0, 0, 0, 0, 1);
        set_at(16, 0, 0, 0, 0, 0);
        lit(25, "long_last", 8'b1_010_000_1);
        lit(26, "long_done", 8'b0_000_010_1);
        lit(28, "long_idle", 8'b0_000_000_0);

        // Abort mid-spray.
        start_test();
        set_at(5, 0, 1, 0, 0, 0);
        set_at(6, 0, 0, 0, 0, 0);
        set_at(9, 0, 0, 0, 1, 0);
        lit(9,  "abort_run", 8'b1_010_000_1);
        set_at(10, 0, 0, 0, 0, 0);
        lit(10, "abort_gap",  8'b0_000_000_1);
        lit(12, "abort_idle", 8'b0_000_000_0);

        // Disinfect not preempted by a later flush.
        start_test();
        set_at(5, 0, 0, 1, 0, 0);
        set_at(6, 0, 0, 0, 0, 0);
        set_at(7, 1, 0, 0, 0, 0);
        set_at(8, 0, 0, 0, 0, 0);
        lit(13, "dis_last",   8'b1_100_000_1);
        lit(14, "dis_done",   8'b0_000_100_1);
        lit(16, "dis_flush",  8'b1_001_000_1);
        lit(35, "dis_flast",  8'b1_001_000_1);
        lit(36, "dis_fdone",  8'b0_000_001_1);
        lit(38, "dis_idle",   8'b0_000_000_0);

        // Reset mid-flush, with a request in the reset cycle.
        start_test();
        set_at(5, 1, 0, 0, 0, 0);
        set_at(6, 0, 0, 0, 0, 0);
        set_at(12, 0, 0, 1, 0, 0);
        reset = 1'b1;
        lit(12, "rst_before", 8'b1_001_000_1);
        set_at(13, 0, 0, 0, 0, 0);
        reset = 1'b0;
        lit(13, "rst_clear",  8'b0_000_000_0);
        lit(26, "rst_nodone", 8'b0_000_000_0);

        // Repeated spray requests during a spray coalesce into one re-run.
        start_test();
        set_at(5, 0, 1, 0, 0, 0);
        set_at(6, 0, 0, 0, 0, 0);
        set_at(8, 0, 1, 0, 0, 0);
        set_at(9, 0, 0, 0, 0, 0);
        set_at(10, 0, 1, 0, 0, 0);
        set_at(11, 0, 0, 0, 0, 0);
        lit(18, "coal_rerun", 8'b1_010_000_1);
        lit(28, "coal_done",  8'b0_000_010_1);
        lit(30, "coal_idle",  8'b0_000_000_0);

        // Abort with req_spray during a flush: flush unaffected, spray dropped.
        start_test();
        set_at(5, 1, 0, 0, 0, 0);
        set_at(6, 0, 0, 0, 0, 0);
        set_at(10, 0, 1, 0, 1, 0);
        set_at(11, 0, 0, 0, 0, 0);
        lit(20, "abf_run",  8'b1_001_000_1);
        lit(26, "abf_done", 8'b0_000_001_1);
        lit(28, "abf_idle", 8'b0_000_000_0);

        // Abort on the last spray cycle suppresses done_spray.
        start_test();
        set_at(5, 0, 1, 0, 0, 0);
        set_at(6, 0, 0, 0, 0, 0);
        set_at(15, 0, 0, 0, 1, 0);
        set_at(16, 0, 0, 0, 0, 0);
        lit(16, "abl_nodone", 8'b0_000_000_1);
        lit(18, "abl_idle",   8'b0_000_000_0);

        go_to(20);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
